param_serializer: RTL and testbench

Parametrised parallel-to-serial converter: captures a DATA_WIDTH-bit word on a load request and shifts it out one bit per clock, LSB- or MSB-first, with an optional appended parity bit. It is the serialization stage ahead of the UART TX frame mux, and replaces the fixed 8-bit serializer. It adds runtime bit-order and parity control, a busy flag, and gap-free back-to-back frames.

---
 rtl/serializer_pkg.sv | 13 +
 rtl/parity_calc.sv | 14 +
 rtl/param_serializer.sv | 144 ++++++++++++++
 tb/tb_param_serializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial converter and its parity helper.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a parametrised word; even or odd selected by par_typ.
module parity_calc
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: LSB/MSB-first, optional parity bit, gap-free back-to-back frames.
module param_serializer
  import serializer_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_VAL   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  ser_en,
  input  logic                  msb_first,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  ser_data,
  output logic                  busy,
  output logic                  ser_done
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pen_q, pen_d;
  logic                    par_q, par_d;
  logic                    ser_data_q, ser_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    par_new;
  logic                    load_ok;
  logic [DATA_WIDTH-1:0]   oriented;

  parity_calc #(.WIDTH(DATA_WIDTH)) u_parity (
    .data    (P_DATA),
    .par_typ (par_typ),
    .parity  (par_new)
  );

  // The word is stored already in transmit order, so the shifter always emits bit 0.
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      oriented[i] = msb_first ? P_DATA[DATA_WIDTH-1-i] : P_DATA[i];
    end
  end

  assign load_ok = ser_en && ((state_q == IDLE) || done_q);

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    pen_d      = pen_q;
    par_d      = par_q;
    ser_data_d = ser_data_q;
    busy_d     = busy_q;
    done_d     = done_q;

    if (load_ok) begin
      state_d    = DATA;
      ser_data_d = oriented[0];
      shreg_d    = oriented >> 1;
      cnt_d      = '0;
      pen_d      = par_en;
      par_d      = par_new;
      busy_d     = 1'b1;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d      = '0;
          ser_data_d = IDLE_VAL;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
        DATA: begin
          if (cnt_q == LAST_IDX) begin
            if (pen_q) begin
              state_d    = PARITY;
              ser_data_d = par_q;
              done_d     = 1'b1;
            end else begin
              state_d    = IDLE;
              cnt_d      = '0;
              ser_data_d = IDLE_VAL;
              busy_d     = 1'b0;
              done_d     = 1'b0;
            end
          end else begin
            cnt_d      = cnt_q + 1'b1;
            ser_data_d = shreg_q[0];
            shreg_d    = shreg_q >> 1;
            done_d     = (cnt_d == LAST_IDX) && !pen_q;
          end
        end
        PARITY: begin
          state_d    = IDLE;
          cnt_d      = '0;
          ser_data_d = IDLE_VAL;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          ser_data_d = IDLE_VAL;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      ser_data_q <= IDLE_VAL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      pen_q      <= pen_d;
      par_q      <= par_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ser_data = ser_data_q;
  assign busy     = busy_q;
  assign ser_done = done_q;

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: 8-bit (idle 0) and 5-bit (idle 1) instances.
module tb_param_serializer;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] p_data8;
  logic       ser_en8, msb8, pen8, ptyp8;
  logic       ser_data8, busy8, done8;

  logic [4:0] p_data5;
  logic       ser_en5, msb5, pen5, ptyp5;
  logic       ser_data5, busy5, done5;

  param_serializer #(.DATA_WIDTH(8), .IDLE_VAL(1'b0)) u_dut8 (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data8), .ser_en(ser_en8),
    .msb_first(msb8), .par_en(pen8), .par_typ(ptyp8),
    .ser_data(ser_data8), .busy(busy8), .ser_done(done8)
  );

  param_serializer #(.DATA_WIDTH(5), .IDLE_VAL(1'b1)) u_dut5 (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data5), .ser_en(ser_en5),
    .msb_first(msb5), .par_en(pen5), .par_typ(ptyp5),
    .ser_data(ser_data5), .busy(busy5), .ser_done(done5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic b;
    logic done;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;

  int n_pass  = 0;
  int n_total = 0;
  bit run     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic score(input string tag, input logic sd, input logic dn, input exp_t e);
    check({tag, "_cycle"}, cyc, e.cyc);
    check({tag, "_bit"}, sd, e.b);
    check({tag, "_done"}, dn, e.done);
  endtask

  // Called on a falling edge; bits is the frame in transmission order, bit 0 first.
  task automatic issue(input int sel, input logic [7:0] data, input logic msb,
                       input logic pen, input logic ptyp, input string bits);
    int   base;
    exp_t e;
    base = cyc + 1;
    for (int k = 0; k < bits.len(); k++) begin
      e.cyc  = base + k;
      e.b    = (bits.substr(k, k) == "1");
      e.done = (k == bits.len() - 1);
      if (sel == 8) q8.push_back(e);
      else          q5.push_back(e);
    end
    if (sel == 8) begin
      p_data8 = data; msb8 = msb; pen8 = pen; ptyp8 = ptyp; ser_en8 = 1'b1;
    end else begin
      p_data5 = data[4:0]; msb5 = msb; pen5 = pen; ptyp5 = ptyp; ser_en5 = 1'b1;
    end
    @(negedge clk);
    ser_en8 = 1'b0;
    ser_en5 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (busy8) begin
        if (q8.size() == 0) check("dut8_spurious_busy", busy8, 1'b0);
        else begin
          e8 = q8.pop_front();
          score("dut8", ser_data8, done8, e8);
        end
      end else begin
        check("dut8_idle_data", ser_data8, 1'b0);
        check("dut8_idle_done", done8, 1'b0);
        if (q8.size() != 0 && q8[0].cyc <= cyc) begin
          check("dut8_busy_missing", busy8, 1'b1);
          void'(q8.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      if (busy5) begin
        if (q5.size() == 0) check("dut5_spurious_busy", busy5, 1'b0);
        else begin
          e5 = q5.pop_front();
          score("dut5", ser_data5, done5, e5);
        end
      end else begin
        check("dut5_idle_data", ser_data5, 1'b1);
        check("dut5_idle_done", done5, 1'b0);
        if (q5.size() != 0 && q5[0].cyc <= cyc) begin
          check("dut5_busy_missing", busy5, 1'b1);
          void'(q5.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    p_data8 = '0; ser_en8 = 0; msb8 = 0; pen8 = 0; ptyp8 = 0;
    p_data5 = '0; ser_en5 = 0; msb5 = 0; pen5 = 0; ptyp5 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst8_ser_data", ser_data8, 1'b0);
    check("rst8_busy", busy8, 1'b0);
    check("rst8_done", done8, 1'b0);
    check("rst5_ser_data", ser_data5, 1'b1);
    check("rst5_busy", busy5, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);

    // A5 LSB-first, no parity
    issue(8, 8'hA5, 1'b0, 1'b0, 1'b0, "10100101");
    repeat (10) @(negedge clk);

    // A5 MSB-first, even parity (four ones -> 0); inputs disturbed mid-frame
    issue(8, 8'hA5, 1'b1, 1'b1, 1'b0, "101001010");
    p_data8 = 8'h3C; msb8 = 1'b0; pen8 = 1'b0; ptyp8 = 1'b1;
    repeat (10) @(negedge clk);

    // Odd parity: 01 -> parity 0, 00 -> parity 1
    issue(8, 8'h01, 1'b0, 1'b1, 1'b1, "100000000");
    repeat (10) @(negedge clk);
    issue(8, 8'h00, 1'b0, 1'b1, 1'b1, "000000001");
    repeat (10) @(negedge clk);

    // Back-to-back: second load held high during the ser_done cycle (cycle 8)
    issue(8, 8'hFF, 1'b0, 1'b0, 1'b0, "11111111");
    repeat (7) @(negedge clk);
    issue(8, 8'h00, 1'b0, 1'b0, 1'b0, "00000000");
    repeat (10) @(negedge clk);

    // Load request in cycle 4 of a frame must be ignored
    issue(8, 8'h0F, 1'b0, 1'b0, 1'b0, "11110000");
    repeat (2) @(negedge clk);
    p_data8 = 8'hAA; msb8 = 1'b1; pen8 = 1'b1; ser_en8 = 1'b1;
    @(negedge clk);
    ser_en8 = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during cycle 3 of a frame, then a clean frame (5A LSB, even parity 0)
    issue(8, 8'hC3, 1'b1, 1'b0, 1'b0, "11000011");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    q8.delete();
    #1;
    check("midrst_ser_data", ser_data8, 1'b0);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_done", done8, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(8, 8'h5A, 1'b0, 1'b1, 1'b0, "010110100");
    repeat (10) @(negedge clk);

    // 5-bit instance, idle level 1: 10011 LSB-first, then MSB-first with even parity 1
    issue(5, 8'h13, 1'b0, 1'b0, 1'b0, "11001");
    repeat (7) @(negedge clk);
    issue(5, 8'h13, 1'b1, 1'b1, 1'b0, "100111");
    repeat (10) @(negedge clk);

    check("dut8_drained", q8.size(), 0);
    check("dut5_drained", q5.size(), 0);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
